// File: rtl/gate_mac_sequencer.sv
// gate_mac_sequencer: walks hidden units through one shared
// gate datapath, one operand fetch and one result handoff per unit.
module gate_mac_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_UNITS  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_units,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_x,
  input  logic [DATA_WIDTH-1:0] mem_h,
  input  logic [DATA_WIDTH-1:0] mem_w0,
  input  logic [DATA_WIDTH-1:0] mem_w1,
  input  logic [DATA_WIDTH-1:0] mem_b,
  output logic [DATA_WIDTH-1:0] dp_x,
  output logic [DATA_WIDTH-1:0] dp_h,
  output logic [DATA_WIDTH-1:0] dp_w0,
  output logic [DATA_WIDTH-1:0] dp_w1,
  output logic [DATA_WIDTH-1:0] dp_b,
  input  logic [DATA_WIDTH-1:0] dp_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ADDR_WIDTH-1:0] res_idx,
  output logic [DATA_WIDTH-1:0] res_data
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EXEC,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN =
    (ADDR_WIDTH+1)'(MAX_UNITS);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_nx;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   len_nx;
  logic [ADDR_WIDTH:0]   req_len;
  logic                  last;

  // Oversized requests run the full unit count rather than wrapping.
  assign req_len = (num_units > MAX_LEN) ? MAX_LEN : num_units;
  assign last    = ({1'b0, idx} == (len - 1'b1));
  assign mem_addr = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      len   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      len   <= len_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    len_nx   = len;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_units == '0) begin
            state_nx = DONE;
          end else begin
            len_nx   = req_len;
            idx_nx   = '0;
            state_nx = FETCH;
          end
        end
      end
      FETCH: state_nx = LOAD;
      LOAD:  state_nx = EXEC;
      EXEC:  state_nx = WRITE;
      WRITE: begin
        if (res_ready) begin
          if (last) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = FETCH;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b1;
    done      = 1'b0;
    mem_en    = 1'b0;
    res_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE):  busy      = 1'b0;
      (state == FETCH): mem_en    = 1'b1;
      (state == WRITE): res_valid = 1'b1;
      (state == DONE):  done      = 1'b1;
      default: ;
    endcase
  end

  // Operands are only written in LOAD so they hold between units.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_x     <= '0;
      dp_h     <= '0;
      dp_w0    <= '0;
      dp_w1    <= '0;
      dp_b     <= '0;
      res_data <= '0;
      res_idx  <= '0;
    end else begin
      if (state == LOAD) begin
        dp_x  <= mem_x;
        dp_h  <= mem_h;
        dp_w0 <= mem_w0;
        dp_w1 <= mem_w1;
        dp_b  <= mem_b;
      end
      if (state == EXEC) begin
        res_data <= dp_out;
        res_idx  <= idx;
      end
    end
  end

endmodule

// File: tb/tb_gate_mac_sequencer.sv
// tb_gate_mac_sequencer: directed run table plus hand-built
// abort and reset sequences against a Q3.5 gate model.
module tb_gate_mac_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] num_units;
  logic       busy;
  logic       done;
  logic       mem_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_x, mem_h, mem_w0, mem_w1, mem_b;
  logic [7:0] dp_x, dp_h, dp_w0, dp_w1, dp_b;
  logic [7:0] dp_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_idx;
  logic [7:0] res_data;

  logic [7:0] mx[16], mh[16], mw0[16], mw1[16], mb[16];
  logic [7:0] got_data[16];
  int         n_cmp;
  int         n_fail;
  int         first_k;

  typedef struct {
    int n;
    int stall_unit;
    int stall_len;
    bit poke;
    int exp_results;
    int exp_done;
  } vec_t;

  vec_t vecs[7];

  gate_mac_sequencer #(
    .DATA_WIDTH(8),
    .MAX_UNITS(16),
    .ADDR_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_units(num_units),
    .busy(busy),
    .done(done),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_x(mem_x),
    .mem_h(mem_h),
    .mem_w0(mem_w0),
    .mem_w1(mem_w1),
    .mem_b(mem_b),
    .dp_x(dp_x),
    .dp_h(dp_h),
    .dp_w0(dp_w0),
    .dp_w1(dp_w1),
    .dp_b(dp_b),
    .dp_out(dp_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_idx(res_idx),
    .res_data(res_data)
  );

  // Q3.5: out = (w0*x + w1*h) >>> 5 + b, wrapping to 8 bits.
  function automatic logic [7:0] gate(input logic [7:0] x,
                                      input logic [7:0] h,
                                      input logic [7:0] w0,
                                      input logic [7:0] w1,
                                      input logic [7:0] b);
    logic signed [15:0] p0;
    logic signed [15:0] p1;
    logic signed [16:0] s;
    p0 = $signed(x) * $signed(w0);
    p1 = $signed(h) * $signed(w1);
    s  = p0 + p1;
    s  = s >>> 5;
    return s[7:0] + b;
  endfunction

  function automatic logic [7:0] exp_unit(input int i);
    return gate(mx[i], mh[i], mw0[i], mw1[i], mb[i]);
  endfunction

  assign dp_out = gate(dp_x, dp_h, dp_w0, dp_w1, dp_b);

  always_ff @(posedge clk) begin
    if (mem_en) begin
      mem_x  <= mx[mem_addr];
      mem_h  <= mh[mem_addr];
      mem_w0 <= mw0[mem_addr];
      mem_w1 <= mw1[mem_addr];
      mem_b  <= mb[mem_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act,
                     input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, req, req);
    end
  endtask

  task automatic do_run(input vec_t v);
    int nres;
    int nreads;
    int stalled;
    int done_k;
    nres    = 0;
    nreads  = 0;
    stalled = 0;
    done_k  = -1;
    first_k = -1;
    num_units = v.n[4:0];
    res_ready = 1'b1;
    start     = 1'b1;
    for (int k = 1; k <= 200 && done_k < 0; k++) begin
      tick();
      start = 1'b0;
      chk("busy_run", int'(busy), 1);
      if (mem_en) begin
        chk("mem_addr", int'(mem_addr), nreads);
        nreads++;
      end
      if (res_valid && int'(res_idx) == v.stall_unit &&
          stalled < v.stall_len) begin
        res_ready = 1'b0;
        stalled++;
        chk("stall_idx", int'(res_idx), v.stall_unit);
        chk("stall_data", int'(res_data),
            int'(exp_unit(v.stall_unit)));
        chk("stall_mem_en", int'(mem_en), 0);
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        if (first_k < 0) first_k = k;
        chk("res_idx", int'(res_idx), nres);
        if (nres < 16) begin
          chk("res_data", int'(res_data), int'(exp_unit(nres)));
          got_data[nres] = res_data;
        end
        nres++;
      end
      if (v.poke && res_valid) start = 1'b1;
      if (done) done_k = k;
    end
    start     = 1'b0;
    res_ready = 1'b1;
    if (done_k < 0) chk("done_timeout", 0, 1);
    chk("done_cycle", done_k, v.exp_done);
    chk("results", nres, v.exp_results);
    chk("reads", nreads, v.exp_results);
    tick();
    chk("idle_busy", int'(busy), 0);
    chk("done_pulse", int'(done), 0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst       = 1'b1;
    start     = 1'b0;
    num_units = '0;
    res_ready = 1'b1;

    mx[0] = 8'h20; mh[0] = 8'h20; mw0[0] = 8'h20;
    mw1[0] = 8'h20; mb[0] = 8'h10;
    mx[1] = 8'h10; mh[1] = 8'hE0; mw0[1] = 8'h40;
    mw1[1] = 8'h20; mb[1] = 8'h08;
    for (int i = 2; i < 15; i++) begin
      mx[i]  = 8'(i * 9);
      mh[i]  = 8'(8'hF0 + i);
      mw0[i] = 8'(i * 7 - 20);
      mw1[i] = 8'(40 - i * 5);
      mb[i]  = 8'(i * 3);
    end
    mx[15] = 8'h7F; mh[15] = 8'h7F; mw0[15] = 8'h7F;
    mw1[15] = 8'h7F; mb[15] = 8'h7F;

    vecs[0] = '{n: 1,  stall_unit: -1, stall_len: 0, poke: 0,
                exp_results: 1,  exp_done: 5};
    vecs[1] = '{n: 16, stall_unit: -1, stall_len: 0, poke: 0,
                exp_results: 16, exp_done: 65};
    vecs[2] = '{n: 3,  stall_unit: 1,  stall_len: 5, poke: 0,
                exp_results: 3,  exp_done: 18};
    vecs[3] = '{n: 0,  stall_unit: -1, stall_len: 0, poke: 0,
                exp_results: 0,  exp_done: 1};
    vecs[4] = '{n: 20, stall_unit: -1, stall_len: 0, poke: 0,
                exp_results: 16, exp_done: 65};
    vecs[5] = '{n: 3,  stall_unit: -1, stall_len: 0, poke: 1,
                exp_results: 3,  exp_done: 13};
    vecs[6] = '{n: 5,  stall_unit: 4,  stall_len: 2, poke: 0,
                exp_results: 5,  exp_done: 23};

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_dp", int'({dp_x, dp_h, dp_w0, dp_w1}), 0);
    chk("rst_dp_b", int'(dp_b), 0);
    chk("rst_res", int'({res_idx, res_data}), 0);

    for (int t = 0; t < 7; t++) begin
      do_run(vecs[t]);
      if (t == 0) begin
        chk("single_first_valid", first_k, 4);
        chk("single_q35", int'(got_data[0]), 8'h50);
      end
      if (t == 1) begin
        chk("full_first_valid", first_k, 4);
        chk("full_unit1_q35", int'(got_data[1]), 8'h08);
        chk("dp_hold_x", int'(dp_x), int'(mx[15]));
      end
    end

    num_units = 5'd4;
    start     = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      start = 1'b0;
      chk("abort_nodone", int'(done), 0);
    end
    chk("abort_unit2", int'(mem_addr), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(res_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_mem_en", int'(mem_en), 0);
    chk("abort_dp_x", int'(dp_x), 0);
    tick();
    chk("abort_done2", int'(done), 0);
    chk("abort_idle", int'(busy), 0);

    do_run('{n: 2, stall_unit: -1, stall_len: 0, poke: 0,
             exp_results: 2, exp_done: 9});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
